// File: rtl/mips_mc_control.sv
// Multi-cycle MIPS control FSM: state register plus combinational output decode.
// Optional macro MIPS_MC_JUMP_EN enables the j instruction (JUMP state, pc_src=2).
module mips_mc_control (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       iord,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_ctrl,
  output logic [1:0] pc_src,
  output logic       pc_en,
  output logic       instr_done,
  output logic       illegal
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_RTEXEC,
    S_RTWB, S_BEQ, S_ADDIEX, S_ADDIWB, S_JUMP, S_HALT
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  state_t     state, next_state;
  logic       rt_ok;
  logic [2:0] rt_alu;

  always_comb begin
    rt_ok  = 1'b1;
    rt_alu = ALU_AND;
    case (funct)
      6'b100000: rt_alu = ALU_ADD;
      6'b100010: rt_alu = ALU_SUB;
      6'b100100: rt_alu = ALU_AND;
      6'b100101: rt_alu = ALU_OR;
      6'b101010: rt_alu = ALU_SLT;
      default:   rt_ok  = 1'b0;
    endcase
  end

  always_comb begin
    next_state = state;
    case (state)
      S_FETCH:  if (mem_ready) next_state = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: next_state = S_MEMADR;
          OP_RTYPE:     next_state = S_RTEXEC;
          OP_BEQ:       next_state = S_BEQ;
          OP_ADDI:      next_state = S_ADDIEX;
`ifdef MIPS_MC_JUMP_EN
          OP_J:         next_state = S_JUMP;
`endif
          default:      next_state = S_HALT;
        endcase
      end
      S_MEMADR: next_state = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  if (mem_ready) next_state = S_MEMWB;
      S_MEMWR:  if (mem_ready) next_state = S_FETCH;
      S_RTEXEC: next_state = rt_ok ? S_RTWB : S_HALT;
      S_ADDIEX: next_state = S_ADDIWB;
      S_MEMWB, S_RTWB, S_BEQ, S_ADDIWB: next_state = S_FETCH;
`ifdef MIPS_MC_JUMP_EN
      S_JUMP:   next_state = S_FETCH;
`endif
      default:  next_state = S_HALT;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_FETCH;
      illegal <= 1'b0;
    end else begin
      state <= next_state;
      if (next_state == S_HALT) illegal <= 1'b1;
    end
  end

  // Outputs are gated by rst_n so they drop the moment reset asserts.
  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    mem_req    = 1'b0;
    iord       = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'd0;
    alu_ctrl   = ALU_AND;
    pc_src     = 2'd0;
    pc_en      = 1'b0;
    instr_done = 1'b0;
    if (rst_n) begin
      case (state)
        S_FETCH: begin
          mem_req   = 1'b1;
          alu_src_b = 2'd1;
          alu_ctrl  = ALU_ADD;
          ir_write  = mem_ready;
          pc_en     = mem_ready;
        end
        S_DECODE: begin
          alu_src_b = 2'd3;
          alu_ctrl  = ALU_ADD;
        end
        S_MEMADR, S_ADDIEX: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'd2;
          alu_ctrl  = ALU_ADD;
        end
        S_MEMRD: begin
          mem_req = 1'b1;
          iord    = 1'b1;
        end
        S_MEMWB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
          instr_done = 1'b1;
        end
        S_MEMWR: begin
          mem_req    = 1'b1;
          iord       = 1'b1;
          mem_write  = 1'b1;
          instr_done = mem_ready;
        end
        S_RTEXEC: begin
          alu_src_a = 1'b1;
          alu_ctrl  = rt_alu;
        end
        S_RTWB: begin
          reg_write  = 1'b1;
          reg_dst    = 1'b1;
          instr_done = 1'b1;
        end
        S_BEQ: begin
          alu_src_a  = 1'b1;
          alu_ctrl   = ALU_SUB;
          pc_src     = 2'd1;
          pc_en      = zero;
          instr_done = 1'b1;
        end
        S_ADDIWB: begin
          reg_write  = 1'b1;
          instr_done = 1'b1;
        end
`ifdef MIPS_MC_JUMP_EN
        S_JUMP: begin
          pc_src     = 2'd2;
          pc_en      = 1'b1;
          instr_done = 1'b1;
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_mc_control.sv
// Directed bench for mips_mc_control: each cycle's control word is compared
// against a hand-computed 18-bit constant.
module tb_mips_mc_control;

  logic       clk, rst_n;
  logic [5:0] opcode, funct;
  logic       zero, mem_ready;
  logic       mem_req, iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write;
  logic       alu_src_a, pc_en, instr_done, illegal;
  logic [1:0] alu_src_b, pc_src;
  logic [2:0] alu_ctrl;

  int errors = 0;
  int checks = 0;

  mips_mc_control dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .mem_req(mem_req), .iord(iord), .mem_write(mem_write),
    .ir_write(ir_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_ctrl(alu_ctrl), .pc_src(pc_src), .pc_en(pc_en),
    .instr_done(instr_done), .illegal(illegal)
  );

  // {mem_req,iord,mem_write,ir_write,reg_dst,mem_to_reg,reg_write,alu_src_a,
  //  alu_src_b[1:0],alu_ctrl[2:0],pc_src[1:0],pc_en,instr_done,illegal}
  logic [17:0] ctl;
  assign ctl = {mem_req, iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
                alu_src_a, alu_src_b, alu_ctrl, pc_src, pc_en, instr_done, illegal};

  localparam logic [17:0] E_OFF    = 18'b0;
  localparam logic [17:0] E_FETCH  = 18'b1_0_0_1_0_0_0_0_01_010_00_1_0_0;
  localparam logic [17:0] E_FSTALL = 18'b1_0_0_0_0_0_0_0_01_010_00_0_0_0;
  localparam logic [17:0] E_DECODE = 18'b0_0_0_0_0_0_0_0_11_010_00_0_0_0;
  localparam logic [17:0] E_MEMADR = 18'b0_0_0_0_0_0_0_1_10_010_00_0_0_0;
  localparam logic [17:0] E_MEMRD  = 18'b1_1_0_0_0_0_0_0_00_000_00_0_0_0;
  localparam logic [17:0] E_MEMWB  = 18'b0_0_0_0_0_1_1_0_00_000_00_0_1_0;
  localparam logic [17:0] E_WSTALL = 18'b1_1_1_0_0_0_0_0_00_000_00_0_0_0;
  localparam logic [17:0] E_WDONE  = 18'b1_1_1_0_0_0_0_0_00_000_00_0_1_0;
  localparam logic [17:0] E_RTSUB  = 18'b0_0_0_0_0_0_0_1_00_110_00_0_0_0;
  localparam logic [17:0] E_RTSLT  = 18'b0_0_0_0_0_0_0_1_00_111_00_0_0_0;
  localparam logic [17:0] E_RTBAD  = 18'b0_0_0_0_0_0_0_1_00_000_00_0_0_0;
  localparam logic [17:0] E_RTWB   = 18'b0_0_0_0_1_0_1_0_00_000_00_0_1_0;
  localparam logic [17:0] E_BEQ1   = 18'b0_0_0_0_0_0_0_1_00_110_01_1_1_0;
  localparam logic [17:0] E_BEQ0   = 18'b0_0_0_0_0_0_0_1_00_110_01_0_1_0;
  localparam logic [17:0] E_ADDIWB = 18'b0_0_0_0_0_0_1_0_00_000_00_0_1_0;
  localparam logic [17:0] E_HALT   = 18'b0_0_0_0_0_0_0_0_00_000_00_0_0_1;
`ifdef MIPS_MC_JUMP_EN
  localparam logic [17:0] E_JUMP   = 18'b0_0_0_0_0_0_0_0_00_000_10_1_1_0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [17:0] exp);
    #1;
    checks++;
    assert (ctl === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b required=%b", tag, ctl, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; opcode = 6'b100011; funct = 6'b0; zero = 1'b0; mem_ready = 1'b1;
    #2;  check("reset_off_a", E_OFF);
    mem_ready = 1'b0; zero = 1'b1; opcode = 6'b000000;
    check("reset_off_b", E_OFF);
    step(); check("reset_off_edge", E_OFF);
    rst_n = 1'b1; mem_ready = 1'b1; zero = 1'b0; opcode = 6'b100011;

    // lw, 5 cycles
    check("lw_fetch", E_FETCH);
    step(); check("lw_decode", E_DECODE);
    step(); check("lw_memadr", E_MEMADR);
    step(); check("lw_memrd", E_MEMRD);
    step(); check("lw_memwb", E_MEMWB);

    // sw with 3 stall cycles in MEMWR
    step(); opcode = 6'b101011; check("sw_fetch", E_FETCH);
    step(); check("sw_decode", E_DECODE);
    step(); check("sw_memadr", E_MEMADR);
    step(); mem_ready = 1'b0; check("sw_stall1", E_WSTALL);
    step(); check("sw_stall2", E_WSTALL);
    step(); check("sw_stall3", E_WSTALL);
    step(); mem_ready = 1'b1; check("sw_done", E_WDONE);

    // R-type sub then slt
    step(); opcode = 6'b000000; funct = 6'b100010; check("sub_fetch", E_FETCH);
    step(); check("sub_decode", E_DECODE);
    step(); check("sub_exec", E_RTSUB);
    step(); check("sub_wb", E_RTWB);
    step(); funct = 6'b101010; check("slt_fetch", E_FETCH);
    step(); check("slt_decode", E_DECODE);
    step(); check("slt_exec", E_RTSLT);
    step(); check("slt_wb", E_RTWB);

    // bad funct -> HALT, sticky
    step(); funct = 6'b000111; check("bad_fetch", E_FETCH);
    step(); check("bad_decode", E_DECODE);
    step(); check("bad_exec", E_RTBAD);
    step(); check("halt_1", E_HALT);
    step(); opcode = 6'b100011; check("halt_2", E_HALT);
    step(); mem_ready = 1'b0; zero = 1'b1; check("halt_3", E_HALT);

    rst_n = 1'b0; check("halt_reset", E_OFF);
    step(); rst_n = 1'b1; zero = 1'b1; opcode = 6'b000100;
    check("fetch_stall_a", E_FSTALL);
    step(); check("fetch_stall_b", E_FSTALL);
    mem_ready = 1'b1; check("beq1_fetch", E_FETCH);

    // beq taken / not taken
    step(); check("beq1_decode", E_DECODE);
    step(); check("beq_taken", E_BEQ1);
    step(); check("beq1_next", E_FETCH);
    step(); zero = 1'b0; check("beq0_decode", E_DECODE);
    step(); check("beq_not_taken", E_BEQ0);
    step(); check("beq0_next", E_FETCH);

    // addi
    step(); opcode = 6'b001000; check("addi_decode", E_DECODE);
    step(); check("addi_exec", E_MEMADR);
    step(); check("addi_wb", E_ADDIWB);

    // j
    step(); opcode = 6'b000010; check("j_fetch", E_FETCH);
    step(); check("j_decode", E_DECODE);
    step();
`ifdef MIPS_MC_JUMP_EN
    check("j_jump", E_JUMP);
    step(); check("j_next", E_FETCH);
`else
    check("j_illegal", E_HALT);
    step(); check("j_illegal_hold", E_HALT);
`endif

    // reset during MEMRD stall
    rst_n = 1'b0; check("pre_lw_reset", E_OFF);
    step(); rst_n = 1'b1; opcode = 6'b100011;
    check("rs_fetch", E_FETCH);
    step(); check("rs_decode", E_DECODE);
    step(); check("rs_memadr", E_MEMADR);
    step(); mem_ready = 1'b0; check("rs_memrd_stall1", E_MEMRD);
    step(); check("rs_memrd_stall2", E_MEMRD);
    rst_n = 1'b0; check("rs_abort", E_OFF);
    mem_ready = 1'b1;
    step(); check("rs_hold", E_OFF);
    rst_n = 1'b1; check("rs_restart", E_FETCH);
    step(); check("rs_restart_decode", E_DECODE);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mips_mc_control.md
# mips_mc_control

Multi-cycle sequencer for the MIPS datapath built from the shared sign-extend, shift-left-2, adder and 2:1 mux primitives. It decodes the opcode and funct fields of the instruction register. It steps one FSM state per clock and drives every mux select, register/memory write enable and ALU control of the datapath. Memory accesses use a ready handshake, so the single shared instruction/data memory can stall the machine.

## Interface
- Parameters: none.
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous active-low reset
- `opcode`  in  6  instr[31:26] from IR
- `funct`  in  6  instr[5:0] from IR
- `zero`  in  1  ALU zero flag
- `mem_ready`  in  1  memory completes current access this cycle
- `mem_req`  out  1  memory access active
- `iord`  out  1  0 = address from PC, 1 = from ALUOut
- `mem_write`  out  1  store strobe
- `ir_write`  out  1  load IR from memory data
- `reg_dst`  out  1  0 = rt, 1 = rd (5-bit mux select)
- `mem_to_reg`  out  1  0 = ALUOut, 1 = MDR
- `reg_write`  out  1  register file write
- `alu_src_a`  out  1  0 = PC, 1 = A
- `alu_src_b`  out  2  0 = B, 1 = const 4, 2 = sign-ext imm, 3 = sign-ext imm << 2
- `alu_ctrl`  out  3  000 and, 001 or, 010 add, 110 sub, 111 slt
- `pc_src`  out  2  0 = ALU result, 1 = ALUOut, 2 = jump target
- `pc_en`  out  1  PC load
- `instr_done`  out  1  one-cycle pulse on last state of an instruction
- `illegal`  out  1  sticky unsupported-opcode/funct flag

## Operation
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTEXEC, RTWB, BEQ, ADDIEX, ADDIWB, JUMP, HALT.
- FETCH: mem_req=1, iord=0, alu_src_a=0, alu_src_b=1, alu_ctrl=add, pc_src=0. Holds while mem_ready=0. When mem_ready=1: ir_write=1, pc_en=1, next DECODE.
- DECODE: alu_src_a=0, alu_src_b=3, alu_ctrl=add (branch target into ALUOut).
  - lw/sw (100011/101011) -> MEMADR
  - R-type (000000) -> RTEXEC
  - beq (000100) -> BEQ
  - addi (001000) -> ADDIEX
  - j (000010) -> JUMP
  - anything else -> HALT with illegal set
- MEMADR: alu_src_a=1, alu_src_b=2, add; lw -> MEMRD, sw -> MEMWR.
- MEMRD: mem_req=1, iord=1; holds until mem_ready, then MEMWB.
- MEMWB: reg_write=1, reg_dst=0, mem_to_reg=1, instr_done=1, -> FETCH.
- MEMWR: mem_req=1, iord=1, mem_write=1; holds until mem_ready. On mem_ready: instr_done=1, -> FETCH.
- RTEXEC: alu_src_a=1, alu_src_b=0, alu_ctrl from funct:
  - 100000 add
  - 100010 sub
  - 100100 and
  - 100101 or
  - 101010 slt
  - other funct -> HALT with illegal set
- RTWB: reg_write=1, reg_dst=1, mem_to_reg=0, instr_done=1, -> FETCH.
- BEQ: alu_src_a=1, alu_src_b=0, sub, pc_src=1, pc_en=zero, instr_done=1, -> FETCH.
- ADDIEX: alu_src_a=1, alu_src_b=2, add, -> ADDIWB.
- ADDIWB: reg_write=1, reg_dst=0, mem_to_reg=0, instr_done=1, -> FETCH.
- JUMP: pc_src=2, pc_en=1, instr_done=1, -> FETCH.
- HALT: all enables 0; held until reset.
- Any output not listed for a state is 0.
- Outputs are decoded combinationally from the state register, plus mem_ready/zero where noted. The state register is the only storage besides `illegal`.

## Timing
- rst_n low: state=FETCH, illegal=0, all enables forced 0 regardless of inputs. First fetch begins on the first clk edge after release.
- Instruction latency with mem_ready tied high:
  - lw 5 cycles
  - sw, R-type, addi 4 cycles
  - beq, j 3 cycles
- Each mem_ready=0 cycle in FETCH/MEMRD/MEMWR adds one cycle. No writes occur while stalled.
- mem_write is held stable for the whole MEMWR stall.
- Reset asserted mid-instruction aborts it immediately with no partial writes. Outputs drop asynchronously.
- `illegal` sets on the edge entering HALT and clears only on reset.

## Configuration
- `MIPS_MC_JUMP_EN` defined: j decoded as above; JUMP state and pc_src=2 exist.
- Not defined: opcode 000010 is illegal (-> HALT) and pc_src never equals 2.

## Test plan
- Reset released, mem_ready=1, IR=lw (0x8C...): FETCH, DECODE, MEMADR, MEMRD, MEMWB over 5 cycles. reg_write=1 with mem_to_reg=1 on cycle 5, instr_done pulses once.
- sw with mem_ready low for 3 cycles in MEMWR: mem_write held 4 cycles. instr_done occurs only on the mem_ready cycle.
- R-type funct 100010 then 101010: alu_ctrl=110 then 111 in RTEXEC. Funct 000111 leads to HALT, illegal=1, and every later cycle shows all enables 0.
- beq: with zero=1, pc_en=1 and pc_src=1 in BEQ; with zero=0, pc_en=0. Next state is FETCH either way.
- Opcode 000010: with MIPS_MC_JUMP_EN, pc_src=2 and pc_en=1 in cycle 3. Without it, HALT and illegal=1.
- rst_n pulsed low during MEMRD stall: reg_write never asserts. The machine restarts at FETCH with iord=0.
